// File: rtl/serial_branch_resolver_if.sv
// Operand/result bus for the bit-serial branch resolver.
// Both handshakes use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both high. The producer keeps valid and its data
// steady until that edge. ready may depend on state, but never on valid.
interface serial_branch_resolver_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] rs2;
    logic [2:0]       funct3;
    logic             out_valid;
    logic             out_ready;
    logic             taken;
    logic             lt;
    logic             eq;
    logic             gt;

    // Operand source and result consumer side.
    modport master (
        output in_valid, rs1, rs2, funct3, out_ready,
        input  in_ready, out_valid, taken, lt, eq, gt
    );

    // Resolver side.
    modport slave (
        input  in_valid, rs1, rs2, funct3, out_ready,
        output in_ready, out_valid, taken, lt, eq, gt
    );
endinterface

// File: rtl/serial_branch_resolver.sv
// Bit-serial branch / set-less-than resolver. It scans the latched operands
// MSB-first, one bit per clock. The first differing bit decides lt. A sign
// difference at the MSB of a signed compare inverts which operand wins.
module serial_branch_resolver #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    serial_branch_resolver_if.slave  bus,
    output logic [1:0]               state_dbg
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] index_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       funct3_q;
    logic             signed_q;
    logic             found_q;
    logic             lt_q, eq_q, gt_q;

    logic accept;
    logic bit_a, bit_b;
    logic first_diff;
    logic last_bit;
    logic top_bit;
    logic diff_lt;
    logic in_signed;

    // Bit slice at the current scan position, plus the handshake decode.
    always_comb begin
        accept     = bus.in_valid & bus.in_ready;
        bit_a      = a_q[index_q];
        bit_b      = b_q[index_q];
        first_diff = (bit_a ^ bit_b) & ~found_q;
        last_bit   = (index_q == '0);
        top_bit    = (index_q == IDX_TOP);
        // At the signed MSB the operand holding a 1 is the negative one.
        diff_lt    = (top_bit & signed_q) ? bit_a : bit_b;
        in_signed  = (bus.funct3 == 3'b100) || (bus.funct3 == 3'b101) ||
                     (bus.funct3 == 3'b010);
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic. The scan always ends at bit 0, so the index never wraps.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = SCAN;
            SCAN: begin
                if (last_bit)                      state_d = DONE;
                else if (EARLY_EXIT && first_diff) state_d = DONE;
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, scan index and the compare result flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            index_q  <= IDX_TOP;
            a_q      <= '0;
            b_q      <= '0;
            funct3_q <= '0;
            signed_q <= 1'b0;
            found_q  <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q      <= bus.rs1;
                        b_q      <= bus.rs2;
                        funct3_q <= bus.funct3;
                        signed_q <= in_signed;
                        found_q  <= 1'b0;
                        index_q  <= IDX_TOP;
                    end
                end
                SCAN: begin
                    if (first_diff) begin
                        lt_q    <= diff_lt;
                        gt_q    <= ~diff_lt;
                        eq_q    <= 1'b0;
                        found_q <= 1'b1;
                    end else if (last_bit && !found_q) begin
                        lt_q <= 1'b0;
                        gt_q <= 1'b0;
                        eq_q <= 1'b1;
                    end
                    if (!last_bit) index_q <= index_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs, the taken decode and the debug state view.
    always_comb begin
        bus.in_ready  = (state_q == IDLE) & ~reset;
        bus.out_valid = (state_q == DONE);
        bus.lt        = lt_q;
        bus.eq        = eq_q;
        bus.gt        = gt_q;
        state_dbg     = state_q;
        case (funct3_q)
            3'b000:  bus.taken = eq_q;
            3'b001:  bus.taken = ~eq_q;
            3'b101:  bus.taken = ~lt_q;
            3'b111:  bus.taken = ~lt_q;
            default: bus.taken = lt_q;
        endcase
    end
endmodule

// File: tb/tb_serial_branch_resolver.sv
// Bench for serial_branch_resolver. Two instances run in lockstep: one with
// early exit and one with constant latency. A known vector table, hand-written
// backpressure and reset sequences, and randomized operations are checked
// against a value-level compare model.
module tb_serial_branch_resolver;
    localparam int WIDTH = 32;
    localparam int RES_W = 20;   // {lt,eq,gt,taken, lat_ee[7:0], lat_ce[7:0]}
    localparam int MAX_CYC = 200;

    logic clk = 1'b0;
    logic reset;
    logic in_valid, out_ready;
    logic [WIDTH-1:0] rs1, rs2;
    logic [2:0] funct3;
    logic [1:0] st0, st1;

    // Clock
    always #5 clk = ~clk;

    serial_branch_resolver_if #(.WIDTH(WIDTH)) b0 ();
    serial_branch_resolver_if #(.WIDTH(WIDTH)) b1 ();

    assign b0.in_valid  = in_valid;
    assign b0.rs1       = rs1;
    assign b0.rs2       = rs2;
    assign b0.funct3    = funct3;
    assign b0.out_ready = out_ready;
    assign b1.in_valid  = in_valid;
    assign b1.rs1       = rs1;
    assign b1.rs2       = rs2;
    assign b1.funct3    = funct3;
    assign b1.out_ready = out_ready;

    serial_branch_resolver #(.WIDTH(WIDTH), .EARLY_EXIT(1'b1)) dut_ee (
        .clk(clk), .reset(reset), .bus(b0), .state_dbg(st0));
    serial_branch_resolver #(.WIDTH(WIDTH), .EARLY_EXIT(1'b0)) dut_ce (
        .clk(clk), .reset(reset), .bus(b1), .state_dbg(st1));

    int total = 0;
    int bad   = 0;
    logic [RES_W-1:0] exp_q[$];

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       f3;
        logic             lt, eq, gt, taken;
        int               lat_ee;
    } vec_t;
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare model: whole-word arithmetic compare, and latency taken from
    // the position of the most significant differing bit.
    function automatic logic [RES_W-1:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [2:0] f3);
        logic sgn, m_lt, m_eq, m_gt, m_tk;
        logic [WIDTH-1:0] x;
        int lat_ee, top;
        sgn  = (f3 == 3'b100) || (f3 == 3'b101) || (f3 == 3'b010);
        m_eq = (a == b);
        m_lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
        m_gt = !m_lt && !m_eq;
        case (f3)
            3'b000:  m_tk = m_eq;
            3'b001:  m_tk = !m_eq;
            3'b101:  m_tk = !m_lt;
            3'b111:  m_tk = !m_lt;
            default: m_tk = m_lt;
        endcase
        x   = a ^ b;
        top = -1;
        for (int i = 0; i < WIDTH; i++) if (x[i]) top = i;
        lat_ee = (top < 0) ? WIDTH + 1 : 2 + (WIDTH - 1 - top);
        return {m_lt, m_eq, m_gt, m_tk, 8'(lat_ee), 8'(WIDTH + 1)};
    endfunction

    function automatic logic [3:0] outs0();
        return {b0.lt, b0.eq, b0.gt, b0.taken};
    endfunction

    function automatic logic [3:0] outs1();
        return {b1.lt, b1.eq, b1.gt, b1.taken};
    endfunction

    // Driver: one operation through both instances. The result is held under
    // backpressure until both are valid, plus 'hold' extra cycles.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2:0] f3, input int hold, input string tag);
        logic [RES_W-1:0] e;
        logic [3:0] r0, r1;
        int cyc, lat0, lat1, extra;
        bit stable_ok, ir_ok;
        e = exp_q.pop_front();
        check({tag, "/idle_ready"}, {31'd0, b0.in_ready & b1.in_ready}, 32'd1);
        rs1 = a; rs2 = b; funct3 = f3; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        // After the accept edge, scramble the inputs; they must be ignored.
        rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom_range(0, 7));
        in_valid = 1'($urandom_range(0, 1));
        cyc = 1; lat0 = 0; lat1 = 0; extra = 0; stable_ok = 1; ir_ok = 1;
        r0 = '0; r1 = '0;
        while ((lat0 == 0 || lat1 == 0 || extra <= hold) && cyc < MAX_CYC) begin
            @(posedge clk); #1;
            cyc++;
            if (b0.in_ready || b1.in_ready) ir_ok = 0;
            if (lat0 != 0 && (!b0.out_valid || outs0() != r0)) stable_ok = 0;
            if (lat1 != 0 && (!b1.out_valid || outs1() != r1)) stable_ok = 0;
            if (lat0 == 0 && b0.out_valid) begin lat0 = cyc; r0 = outs0(); end
            if (lat1 == 0 && b1.out_valid) begin lat1 = cyc; r1 = outs1(); end
            if (lat0 != 0 && lat1 != 0) extra++;
        end
        check({tag, "/timeout"}, {31'd0, cyc < MAX_CYC}, 32'd1);
        check({tag, "/ee_result"}, {28'd0, r0}, {28'd0, e[19:16]});
        check({tag, "/ee_latency"}, lat0, {24'd0, e[15:8]});
        check({tag, "/ce_result"}, {28'd0, r1}, {28'd0, e[19:16]});
        check({tag, "/ce_latency"}, lat1, {24'd0, e[7:0]});
        check({tag, "/held_stable"}, {31'd0, stable_ok}, 32'd1);
        check({tag, "/busy_not_ready"}, {31'd0, ir_ok}, 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "/released_valid"}, {30'd0, b0.out_valid, b1.out_valid}, 32'd0);
        check({tag, "/released_ready"}, {30'd0, b0.in_ready, b1.in_ready}, 32'd3);
    endtask

    initial begin
        logic [WIDTH-1:0] a, b;
        logic [2:0] f3;
        bit quiet;

        vecs[0]  = '{32'h00000005, 32'h00000005, 3'b000, 0, 1, 0, 1, 33};
        vecs[1]  = '{32'h00000005, 32'h00000005, 3'b001, 0, 1, 0, 0, 33};
        vecs[2]  = '{32'hFFFFFFFF, 32'h00000001, 3'b100, 1, 0, 0, 1, 2};
        vecs[3]  = '{32'hFFFFFFFF, 32'h00000001, 3'b110, 0, 0, 1, 0, 2};
        vecs[4]  = '{32'hFFFFFFFF, 32'h00000001, 3'b111, 0, 0, 1, 1, 2};
        vecs[5]  = '{32'h00000010, 32'h00000011, 3'b111, 1, 0, 0, 0, 33};
        vecs[6]  = '{32'h80000000, 32'h00000000, 3'b010, 1, 0, 0, 1, 2};
        vecs[7]  = '{32'h00000001, 32'h00000002, 3'b110, 1, 0, 0, 1, 32};
        vecs[8]  = '{32'h00000003, 32'h00000003, 3'b011, 0, 1, 0, 0, 33};
        vecs[9]  = '{32'h7FFFFFFF, 32'h80000000, 3'b101, 0, 0, 1, 1, 2};
        vecs[10] = '{32'h80000000, 32'h7FFFFFFF, 3'b011, 0, 0, 1, 0, 2};

        // Reset
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        rs1 = '0; rs2 = '0; funct3 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/out_valid", {30'd0, b0.out_valid, b1.out_valid}, 32'd0);
        check("reset/in_ready_low", {30'd0, b0.in_ready, b1.in_ready}, 32'd0);
        check("reset/outputs", {24'd0, outs0(), outs1()}, 32'd0);
        reset = 1'b0;
        #1;
        check("reset/in_ready_after", {30'd0, b0.in_ready, b1.in_ready}, 32'd3);

        // Vector table
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back({vecs[i].lt, vecs[i].eq, vecs[i].gt, vecs[i].taken,
                             8'(vecs[i].lat_ee), 8'(WIDTH + 1)});
            run_op(vecs[i].a, vecs[i].b, vecs[i].f3, 0, $sformatf("vec%0d", i));
        end

        // Backpressure: result held for extra cycles with out_ready low
        exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1, 8'd2, 8'(WIDTH + 1)});
        run_op(32'hFFFFFFFF, 32'h00000001, 3'b100, 5, "backpressure");

        // Reset in the middle of a scan
        rs1 = 32'd3; rs2 = 32'd3; funct3 = 3'b000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset/out_valid", {30'd0, b0.out_valid, b1.out_valid}, 32'd0);
        check("midreset/outputs", {24'd0, outs0(), outs1()}, 32'd0);
        check("midreset/in_ready_low", {30'd0, b0.in_ready, b1.in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("midreset/in_ready_after", {30'd0, b0.in_ready, b1.in_ready}, 32'd3);
        quiet = 1;
        repeat (40) begin
            @(posedge clk); #1;
            if (b0.out_valid || b1.out_valid) quiet = 0;
        end
        check("midreset/no_result", {31'd0, quiet}, 32'd1);
        exp_q.push_back(model(32'd1, 32'd2, 3'b110));
        run_op(32'd1, 32'd2, 3'b110, 0, "after_reset");

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom; b = a; end
                2: begin a = $urandom; b = a ^ (32'd1 << $urandom_range(0, WIDTH - 1)); end
                default: begin
                    a = 32'($urandom_range(0, 7)); b = 32'($urandom_range(0, 7));
                    a[WIDTH-1] = 1'($urandom_range(0, 1));
                    b[WIDTH-1] = 1'($urandom_range(0, 1));
                end
            endcase
            f3 = 3'($urandom_range(0, 7));
            exp_q.push_back(model(a, b, f3));
            run_op(a, b, f3, $urandom_range(0, 2), $sformatf("rand%0d", n));
        end

        // Report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_branch_resolver.md
Name: serial_branch_resolver

Overview:
- Bit-serial, minimum-area branch and set-less-than resolver for the tiny RISC-V core.
- Consumes two register operands plus funct3 under a valid/ready handshake.
- Scans the operands MSB-first, one bit per clock, and produces lt/eq/gt and a branch-taken / SLT result under a second valid/ready handshake.
- Sits between operand read and the PC-select / writeback mux.
- Replaces a full-width parallel compare chain with a one-bit slice, a bit index counter and a small FSM.

Parameters:
- WIDTH, 32, operand width in bits.
- EARLY_EXIT, 1.
  - 1: finish at the first differing bit.
  - 0: always scan all WIDTH bits, giving constant latency.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  rs1/rs2/funct3 are valid.
- in_ready  output  1  block can accept a new operation.
- rs1  input  WIDTH  operand a.
- rs2  input  WIDTH  operand b.
- funct3  input  3  operation select.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- taken  output  1  branch taken, or SLT/SLTU result bit.
- lt  output  1  a < b under the selected signedness.
- eq  output  1  a == b.
- gt  output  1  a > b; equals ~lt & ~eq once out_valid is high.

Behaviour:
- FSM states: IDLE, SCAN, DONE.
  - in_ready = (state == IDLE) & ~reset.
  - out_valid = (state == DONE).
- Reset (synchronous, takes priority over every other event):
  - state <= IDLE; index <= WIDTH-1; latched operands cleared.
  - lt/eq/gt/taken <= 0.
  - Reset during SCAN or DONE abandons the operation. No out_valid follows.
- Signedness: signed = (funct3 == 3'b100 | 3'b101 | 3'b010). All other encodings compare unsigned.
- IDLE:
  - On in_valid & in_ready, latch rs1, rs2, funct3 and signed.
  - Clear the found flag; index <= WIDTH-1; next state SCAN.
- SCAN, one bit per cycle at position index:
  - First difference (a[index] != b[index] and found == 0):
    - At index == WIDTH-1 with signed set: lt <= a[index].
    - Otherwise: lt <= b[index].
    - eq <= 0; found <= 1.
    - If EARLY_EXIT == 1, next state is DONE.
  - Any further differing bit is ignored.
  - At index == 0 with no difference found: lt <= 0, eq <= 1. Next state is DONE.
  - If index == 0 is reached, next state is DONE in every case.
  - Otherwise index <= index - 1.
- DONE:
  - gt = ~lt & ~eq.
  - taken is decoded combinationally from the latched funct3:
    - 000 BEQ: eq
    - 001 BNE: ~eq
    - 100 BLT: lt
    - 101 BGE: ~lt
    - 110 BLTU: lt
    - 111 BGEU: ~lt
    - 010 SLT: lt
    - 011 SLTU: lt
  - All outputs stay stable while out_ready is low (unbounded backpressure).
  - On out_ready, next state is IDLE. in_ready is not asserted in that same cycle, so there is no back-to-back accept.
- Latency:
  - Accept edge is T0. Bit WIDTH-1-k is compared in cycle T0+1+k.
  - With EARLY_EXIT=1, out_valid rises in cycle T0+2+k. Minimum is 2 cycles (MSB differs); maximum is WIDTH+1 (equal operands, or difference only at bit 0).
  - With EARLY_EXIT=0, latency is always WIDTH+1.
- Input behaviour:
  - rs1/rs2/funct3 are only sampled at the accept edge. Later changes have no effect.
  - in_valid outside IDLE is ignored.
- Outside DONE:
  - lt/eq/gt/taken hold their last values and are don't-care.
  - out_valid is the only qualifier.
- Index counter is ceil(log2(WIDTH)) bits. It never wraps below 0, because DONE is forced at index 0.

Test Plan:
- Equal, max latency: rs1=0x00000005, rs2=0x00000005, funct3=000 → out_valid in cycle T0+33; eq=1, lt=0, gt=0, taken=1. Repeat with funct3=001 → taken=0.
- Signed MSB early exit: rs1=0xFFFFFFFF, rs2=0x00000001, funct3=100 → out_valid at T0+2; lt=1, eq=0, gt=0, taken=1.
- Unsigned, same operands: rs1=0xFFFFFFFF, rs2=0x00000001, funct3=110 → out_valid at T0+2; lt=0, gt=1, taken=0. funct3=111 → taken=1.
- LSB-only difference: rs1=0x00000010, rs2=0x00000011, funct3=111 (BGEU) → out_valid at T0+33; lt=1, taken=0. Repeat with EARLY_EXIT=0 and rs1=0x80000000, rs2=0 signed (funct3=010) → latency still 33; lt=1, taken=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_valid, lt, eq, gt, taken all stable and in_ready=0 throughout. Raise out_ready → IDLE next cycle; in_ready=1 one cycle later than the handshake.
- Reset mid-op: accept rs1=3, rs2=3, assert reset in cycle T0+10 → next cycle state is IDLE, out_valid=0, outputs 0, in_ready=1 after reset deasserts. A following op (rs1=1, rs2=2, funct3=110) completes correctly with lt=1, taken=1.
